parallel_recv_chk: RTL and testbench
====================================

// Module: parallel_recv_chk
// PURPOSE
//  Parametrised receive-side data checker behind the parallel link aligner.
//  Compares aligned words against a locally generated expected sequence.
//  Two pattern modes: block-constant (value held per block) and per-word increment.
//  Optional seeding from the first received word; single-block or continuous run.
//  Saturating error and word counters; loss-of-lock detection after N consecutive errors.
// PARAMETERS
//  DW       32    data/reference width; reference wraps modulo 2^DW
//  BLK_LEN  1024  words per block (>=2); block counter width = clog2(BLK_LEN)
//  ECW      8     ERR_CNT width, saturating
//  WCW      16    WORD_CNT width, saturating
//  LOSS_THR 8     consecutive mismatches that force LOST (1..255)
// PORTS
//  CLK      in  1    clock
//  RST      in  1    asynchronous active-high reset
//  CLR      in  1    sync clear; same effect as RST
//  ALIGNED  in  1    aligner locked; words accepted only when 1
//  DIPUSH   in  1    DIN valid this cycle
//  DIN      in  DW   received word
//  INIT     in  1    arm a new check run (single-cycle pulse)
//  MODE     in  1    0: block-constant, 1: per-word increment; sampled at INIT
//  SEED_EN  in  1    1: first word after INIT loads reference; sampled at INIT
//  CONT     in  1    1: run blocks back-to-back until CLR/INIT; sampled at INIT
//  ERR_CNT  out ECW  mismatch count, saturating at all-ones
//  WORD_CNT out WCW  checked-word count, saturating at all-ones
//  LOCKED   out 1    state is TRACK
//  LOST     out 1    sticky: LOST state entered since last RST/CLR
// BEHAVIOUR
//  - Reset/CLR: state IDLE, ref=0, all outputs 0, pipeline cleared. Priority CLR > INIT > data.
//  - dv = ALIGNED & DIPUSH. Data register loads DIN on every DIPUSH (legacy rule).
//  - FSM IDLE/ARMED/TRACK/LOST. INIT from any state -> ARMED, block cnt := BLK_LEN-1,
//    consecutive-error cnt := 0; ref is NOT cleared by INIT.
//  - ARMED, dv: SEED_EN=1 -> ref := DIN (+1 if MODE=1), word not compared, block cnt
//    decrements; SEED_EN=0 -> word compared as in TRACK. Either way -> TRACK.
//  - TRACK, dv: stage 1 captures DIN, expected=ref, chk=1; MODE=1 -> ref += 1.
//    Block cnt decrements; at cnt==0: MODE=0 -> ref += 1; CONT=1 reload BLK_LEN-1,
//    stay TRACK; CONT=0 -> IDLE.
//  - IDLE/LOST: dv captured with chk=0; no compare, no count, ref frozen.
//  - Stage 2 (one edge after capture): if chk: WORD_CNT += 1 (sat); mismatch ->
//    ERR_CNT += 1 (sat), consec += 1; match -> consec := 0.
//  - Latency: word at edge N affects ERR_CNT/WORD_CNT at edge N+1 (visible cycle N+2).
//  - consec reaching LOSS_THR while TRACK -> LOST, LOST flag := 1. Word already in
//    stage 1 at that edge is still evaluated and counted.
//  - INIT in same cycle as dv: INIT wins, word gets chk=0. ALIGNED low: no state change.
//  - Counters hold at all-ones; no wrap. ref wraps 2^DW-1 -> 0 silently.
// TESTING
//  1 INIT MODE0 SEED0 CONT0; 1024 words 0 -> ERR_CNT 0, WORD_CNT 1024, IDLE; next run words 1 -> 0 err.
//  2 As 1, word idx 10 = 0x5 -> ERR_CNT 1 at second edge after push; LOCKED stays 1.
//  3 MODE1 SEED1; DIN 0xFFFFFFFE,FFFFFFFF,0,1.. -> 0 errors, WORD_CNT = words-1.
//  4 LOSS_THR 4; 4 bad words -> LOST=1, LOCKED=0, ERR_CNT 4; more bad words no count; INIT re-arms, LOST stays 1.
//  5 LOSS_THR 255, 300 bad words interleaved with good -> ERR_CNT saturates 255.
//  6 RST mid-block and CLR+INIT+DIPUSH same cycle -> all outputs 0, state IDLE, ref 0.

Source files
------------

// File: rtl/parallel_recv_chk_if.sv
// rtl/parallel_recv_chk_if.sv - signal bundle between the link aligner side and the data checker
interface parallel_recv_chk_if #(
    parameter int DW  = 32,
    parameter int ECW = 8,
    parameter int WCW = 16
);
    logic           CLR;
    logic           ALIGNED;
    logic           DIPUSH;
    logic [DW-1:0]  DIN;
    logic           INIT;
    logic           MODE;
    logic           SEED_EN;
    logic           CONT;
    logic [ECW-1:0] ERR_CNT;
    logic [WCW-1:0] WORD_CNT;
    logic           LOCKED;
    logic           LOST;

    modport master (
        output CLR, ALIGNED, DIPUSH, DIN, INIT, MODE, SEED_EN, CONT,
        input  ERR_CNT, WORD_CNT, LOCKED, LOST
    );

    modport slave (
        input  CLR, ALIGNED, DIPUSH, DIN, INIT, MODE, SEED_EN, CONT,
        output ERR_CNT, WORD_CNT, LOCKED, LOST
    );
endinterface

// File: rtl/parallel_recv_chk.sv
// rtl/parallel_recv_chk.sv - receive-side checker comparing aligned words against a local reference sequence
module parallel_recv_chk #(
    parameter int DW       = 32,
    parameter int BLK_LEN  = 1024,
    parameter int ECW      = 8,
    parameter int WCW      = 16,
    parameter int LOSS_THR = 8
) (
    input  logic              CLK,
    input  logic              RST,
    parallel_recv_chk_if.slave bus
);
    localparam int BCW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [BCW-1:0] BLK_LAST = BCW'(BLK_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRACK, S_LOST} state_t;

    state_t         state;
    state_t         state_nxt;

    logic [DW-1:0]  ref_q;
    logic [BCW-1:0] blk_cnt;
    logic           mode_q;
    logic           seed_q;
    logic           cont_q;

    logic [DW-1:0]  din_q;
    logic [DW-1:0]  exp_q;
    logic           chk_q;

    logic [ECW-1:0] err_q;
    logic [WCW-1:0] word_q;
    logic [7:0]     consec;
    logic           lost_q;

    logic           dv;
    logic           take;
    logic           seed_ld;
    logic           blk_end;
    logic           mismatch;
    logic [7:0]     consec_inc;
    logic [7:0]     consec_eval;
    logic           loss_hit;

    assign dv          = bus.ALIGNED & bus.DIPUSH;
    assign blk_end     = (blk_cnt == '0);
    assign mismatch    = chk_q & (din_q != exp_q);
    assign consec_inc  = (&consec) ? consec : consec + 8'd1;
    assign consec_eval = !chk_q ? consec : (mismatch ? consec_inc : 8'd0);
    // Loss is judged on the run length including the word being evaluated this edge.
    assign loss_hit    = (state == S_TRACK) && (consec_eval >= 8'(LOSS_THR));

    // State register; CLR behaves as a synchronous copy of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else if (bus.CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: INIT beats loss detection, loss beats the normal data flow.
    always_comb begin
        state_nxt = state;
        if (bus.INIT) begin
            state_nxt = S_ARMED;
        end else if (loss_hit) begin
            state_nxt = S_LOST;
        end else if (take && blk_end && !cont_q) begin
            state_nxt = S_IDLE;
        end else if (take || seed_ld) begin
            state_nxt = S_TRACK;
        end
    end

    // Outputs and per-word decode: a word is compared in TRACK, or in ARMED when not seeding.
    always_comb begin
        take         = 1'b0;
        seed_ld      = 1'b0;
        bus.LOCKED   = (state == S_TRACK);
        bus.LOST     = lost_q;
        bus.ERR_CNT  = err_q;
        bus.WORD_CNT = word_q;
        if (dv && !bus.INIT) begin
            take    = (state == S_TRACK) || ((state == S_ARMED) && !seed_q);
            seed_ld = (state == S_ARMED) && seed_q;
        end
    end

    // Reference generator, block position and run configuration latched at INIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ref_q   <= '0;
            blk_cnt <= '0;
            mode_q  <= 1'b0;
            seed_q  <= 1'b0;
            cont_q  <= 1'b0;
        end else if (bus.CLR) begin
            ref_q   <= '0;
            blk_cnt <= '0;
            mode_q  <= 1'b0;
            seed_q  <= 1'b0;
            cont_q  <= 1'b0;
        end else if (bus.INIT) begin
            blk_cnt <= BLK_LAST;
            mode_q  <= bus.MODE;
            seed_q  <= bus.SEED_EN;
            cont_q  <= bus.CONT;
        end else if (seed_ld) begin
            ref_q   <= bus.DIN + DW'(mode_q);
            blk_cnt <= blk_end ? BLK_LAST : blk_cnt - BCW'(1);
        end else if (take) begin
            // Block-constant mode steps once per block, increment mode once per word.
            ref_q   <= ref_q + DW'(mode_q | blk_end);
            blk_cnt <= blk_end ? BLK_LAST : blk_cnt - BCW'(1);
        end
    end

    // Stage 1: hold the received word with its expected value and compare flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            din_q <= '0;
            exp_q <= '0;
            chk_q <= 1'b0;
        end else if (bus.CLR) begin
            din_q <= '0;
            exp_q <= '0;
            chk_q <= 1'b0;
        end else begin
            if (bus.DIPUSH) begin
                din_q <= bus.DIN;
            end
            if (take) begin
                exp_q <= ref_q;
            end
            chk_q <= take;
        end
    end

    // Stage 2: saturating counters, consecutive-error run and sticky loss flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q  <= '0;
            word_q <= '0;
            consec <= '0;
            lost_q <= 1'b0;
        end else if (bus.CLR) begin
            err_q  <= '0;
            word_q <= '0;
            consec <= '0;
            lost_q <= 1'b0;
        end else begin
            if (chk_q && !(&word_q)) begin
                word_q <= word_q + WCW'(1);
            end
            if (mismatch && !(&err_q)) begin
                err_q <= err_q + ECW'(1);
            end
            consec <= bus.INIT ? 8'd0 : consec_eval;
            if (loss_hit && !bus.INIT) begin
                lost_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_parallel_recv_chk.sv
// tb/tb_parallel_recv_chk.sv - self-checking bench for parallel_recv_chk
module tb_parallel_recv_chk;
    localparam int DW       = 32;
    localparam int BLK      = 1024;
    localparam int THR_A    = 4;
    localparam int ERR_MAX  = 255;
    localparam int WORD_MAX = 65535;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_TRACK = 2;
    localparam int M_LOST  = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    parallel_recv_chk_if #(.DW(DW), .ECW(8), .WCW(16)) if_a ();
    parallel_recv_chk_if #(.DW(DW), .ECW(8), .WCW(16)) if_b ();

    assign if_b.CLR     = if_a.CLR;
    assign if_b.ALIGNED = if_a.ALIGNED;
    assign if_b.DIPUSH  = if_a.DIPUSH;
    assign if_b.DIN     = if_a.DIN;
    assign if_b.INIT    = if_a.INIT;
    assign if_b.MODE    = if_a.MODE;
    assign if_b.SEED_EN = if_a.SEED_EN;
    assign if_b.CONT    = if_a.CONT;

    parallel_recv_chk #(.DW(DW), .BLK_LEN(BLK), .ECW(8), .WCW(16), .LOSS_THR(THR_A)) u_a (
        .CLK (CLK),
        .RST (RST),
        .bus (if_a.slave)
    );

    parallel_recv_chk #(.DW(DW), .BLK_LEN(BLK), .ECW(8), .WCW(16), .LOSS_THR(255)) u_b (
        .CLK (CLK),
        .RST (RST),
        .bus (if_b.slave)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instance u_a) ----------------
    typedef struct {
        bit          chk;
        logic [31:0] data;
        logic [31:0] expv;
    } pend_t;

    int          m_st     = M_IDLE;
    logic [31:0] m_ref    = '0;
    int          m_pos    = 0;
    int          m_err    = 0;
    int          m_word   = 0;
    int          m_consec = 0;
    bit          m_lost   = 0;
    bit          m_mode   = 0;
    bit          m_seed   = 0;
    bit          m_cont   = 0;
    pend_t       m_p      = '{0, 32'h0, 32'h0};

    task automatic model_step();
        pend_t np;
        bit    dv;
        bit    loss;
        if (RST || if_a.CLR) begin
            m_st = M_IDLE; m_ref = '0; m_pos = 0; m_err = 0; m_word = 0;
            m_consec = 0; m_lost = 0; m_mode = 0; m_seed = 0; m_cont = 0;
            m_p = '{0, 32'h0, 32'h0};
            return;
        end
        if (m_p.chk) begin
            if (m_word < WORD_MAX) m_word++;
            if (m_p.data != m_p.expv) begin
                if (m_err < ERR_MAX) m_err++;
                m_consec++;
            end else begin
                m_consec = 0;
            end
        end
        loss    = (m_st == M_TRACK) && (m_consec >= THR_A);
        np.chk  = 0;
        np.data = if_a.DIPUSH ? if_a.DIN : m_p.data;
        np.expv = m_p.expv;
        dv      = if_a.ALIGNED && if_a.DIPUSH;
        if (if_a.INIT) begin
            m_st = M_ARMED; m_pos = 0; m_consec = 0;
            m_mode = if_a.MODE; m_seed = if_a.SEED_EN; m_cont = if_a.CONT;
        end else begin
            if (dv && (m_st == M_TRACK || (m_st == M_ARMED && !m_seed))) begin
                np.chk  = 1;
                np.expv = m_ref;
                if (m_mode) m_ref = m_ref + 32'd1;
                if (m_pos == BLK - 1) begin
                    if (!m_mode) m_ref = m_ref + 32'd1;
                    m_pos = 0;
                    m_st  = m_cont ? M_TRACK : M_IDLE;
                end else begin
                    m_pos++;
                    m_st = M_TRACK;
                end
            end else if (dv && m_st == M_ARMED) begin
                m_ref = if_a.DIN + (m_mode ? 32'd1 : 32'd0);
                m_pos = 1;
                m_st  = M_TRACK;
            end
            if (loss) begin
                m_st   = M_LOST;
                m_lost = 1;
            end
        end
        m_p = np;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
            #1;
            check("mon_err_cnt",  64'(if_a.ERR_CNT),  64'(m_err));
            check("mon_word_cnt", 64'(if_a.WORD_CNT), 64'(m_word));
            check("mon_locked",   64'(if_a.LOCKED),   64'(m_st == M_TRACK));
            check("mon_lost",     64'(if_a.LOST),     64'(m_lost));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit clr, input bit init, input bit al, input bit push,
                         input logic [31:0] d, input bit mode, input bit seed, input bit cont);
        if_a.CLR = clr; if_a.INIT = init; if_a.ALIGNED = al; if_a.DIPUSH = push;
        if_a.DIN = d; if_a.MODE = mode; if_a.SEED_EN = seed; if_a.CONT = cont;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        drive(0, 0, 1, 1, d, 0, 0, 0);
        step();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 1, 0, 32'h0, 0, 0, 0);
        repeat (n) step();
    endtask

    task automatic arm(input bit mode, input bit seed, input bit cont);
        drive(0, 1, 1, 0, 32'h0, mode, seed, cont);
        step();
    endtask

    task automatic clear();
        drive(1, 0, 1, 0, 32'h0, 0, 0, 0);
        step();
    endtask

    task automatic check_a(input string nm, input int err, input int word, input bit lk, input bit lost);
        check({nm, "_err"},    64'(if_a.ERR_CNT),  64'(err));
        check({nm, "_word"},   64'(if_a.WORD_CNT), 64'(word));
        check({nm, "_locked"}, 64'(if_a.LOCKED),   64'(lk));
        check({nm, "_lost"},   64'(if_a.LOST),     64'(lost));
    endtask

    typedef struct {
        bit          clr;
        bit          init;
        bit          al;
        bit          push;
        logic [31:0] din;
        int          err;
        int          word;
        bit          lk;
        bit          lost;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int burst;
        logic [31:0] d;

        tbl.push_back('{1, 0, 1, 0, 32'h0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 32'h0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h7, 0, 2, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h7, 1, 3, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h7, 2, 4, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h7, 3, 5, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 32'h0, 4, 6, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 32'h0, 4, 6, 0, 1});
        tbl.push_back('{0, 0, 1, 1, 32'h7, 4, 6, 0, 1});
        tbl.push_back('{0, 0, 1, 1, 32'h7, 4, 6, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 32'h0, 4, 6, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 32'h0, 4, 6, 0, 1});
        tbl.push_back('{0, 0, 1, 1, 32'h0, 4, 6, 1, 1});
        tbl.push_back('{0, 0, 1, 0, 32'h0, 4, 7, 1, 1});
        tbl.push_back('{1, 1, 1, 1, 32'h9, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 32'h0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 32'h0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 32'h0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 32'h0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 32'h0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 32'h0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 32'h0, 0, 1, 1, 0});

        drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        check_a("reset", 0, 0, 0, 0);
        RST = 1'b0;
        idle(2);

        // Block-constant run of zeros, then a second run continuing at 1.
        arm(0, 0, 0);
        for (int i = 0; i < BLK; i++) push_word(32'h0);
        idle(2);
        check_a("blk0", 0, BLK, 0, 0);
        arm(0, 0, 0);
        for (int i = 0; i < BLK; i++) push_word(32'h1);
        idle(2);
        check_a("blk1", 0, 2 * BLK, 0, 0);

        // Single bad word at index 10 shows up one edge after the following push.
        arm(0, 0, 0);
        for (int i = 0; i < 10; i++) push_word(32'h2);
        push_word(32'h5);
        check("bad10_err_early", 64'(if_a.ERR_CNT), 64'd0);
        push_word(32'h2);
        check_a("bad10", 1, 2 * BLK + 11, 1, 0);
        for (int i = 12; i < BLK; i++) push_word(32'h2);
        idle(2);
        check_a("bad10_end", 1, 3 * BLK, 0, 0);

        // Seeded increment run across the 2^DW wrap.
        clear();
        arm(1, 1, 0);
        push_word(32'hFFFF_FFFE);
        push_word(32'hFFFF_FFFF);
        for (int i = 0; i < 18; i++) push_word(32'(i));
        idle(2);
        check_a("wrap", 0, 19, 1, 0);

        // Loss, sticky flag, CLR/INIT/data collisions and ALIGNED gating.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].clr, tbl[i].init, tbl[i].al, tbl[i].push, tbl[i].din, 0, 0, 0);
            step();
            check_a($sformatf("tbl%0d", i), tbl[i].err, tbl[i].word, tbl[i].lk, tbl[i].lost);
        end

        // Interleaved good/bad words saturate the error counter without loss.
        clear();
        arm(0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            push_word(32'h0);
            push_word(32'h1);
        end
        idle(2);
        check("sat_b_err",  64'(if_b.ERR_CNT),  64'd255);
        check("sat_b_word", 64'(if_b.WORD_CNT), 64'd600);
        check("sat_b_lost", 64'(if_b.LOST),     64'd0);
        check("sat_a_err",  64'(if_a.ERR_CNT),  64'd255);

        // Asynchronous reset in the middle of an increment block.
        clear();
        arm(1, 0, 0);
        for (int i = 0; i < 5; i++) push_word(32'(i));
        drive(0, 0, 1, 1, 32'h5, 0, 0, 0);
        #3;
        RST = 1'b1;
        #1;
        check_a("async_rst", 0, 0, 0, 0);
        step();
        RST = 1'b0;
        arm(1, 0, 0);
        push_word(32'h0);
        idle(2);
        check_a("post_rst", 0, 1, 1, 0);

        // Randomised traffic checked by the reference model.
        clear();
        burst = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 99) < 2) burst = $urandom_range(1, 7);
            d = m_ref;
            if (burst > 0) begin
                d = ~m_ref;
                burst--;
            end else if ($urandom_range(0, 99) < 3) begin
                d = $urandom;
            end
            drive($urandom_range(0, 1999) == 0,
                  $urandom_range(0, 1199) == 0 || c == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) < 8,
                  d,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0);
            step();
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
